// File: rtl/ncl_mr3_arbiter.sv
// ---------------------------------------------------------------------------
// ncl_mr3_arbiter
//
// Two-requester round-robin arbiter that feeds symbols into an NCL ring stage
// over a 1-of-3 multirail channel. Each granted symbol becomes one DATA
// wavefront on Z. The arbiter then waits for the downstream completion ZCOMP
// to rise, returns Z to NULL, and waits for ZCOMP to fall before it accepts
// the next symbol. ZCOMP is asynchronous, so it is synchronized first.
//
// Parameters
//   SYNC_STAGES  flops in the ZCOMP synchronizer (2..4)
//   TIMEOUT      cycles a handshake phase may take before stall is raised
//
// Ports
//   clk          rising-edge clock for all state
//   init         synchronous active-high reset
//   req0/req1    requester has a symbol pending, held until its grant
//   sym0/sym1    requester symbol, 0..2 legal, 3 illegal
//   gnt0/gnt1    one-cycle pulse, requester symbol consumed
//   Z            1-of-3 multirail output, 000 = NULL
//   ZCOMP        asynchronous completion from the downstream NCL stage
//   busy         a wavefront is in flight (DATA or NULLW)
//   stall        sticky, a handshake phase reached TIMEOUT cycles
//   sym_err      one-cycle pulse, an illegal symbol was consumed
//   tok_cnt      number of DATA wavefronts issued, wrapping at 16 bits
// ---------------------------------------------------------------------------
module ncl_mr3_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        init,
  input  logic        req0,
  input  logic [1:0]  sym0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [1:0]  sym1,
  output logic        gnt1,
  output logic [2:0]  Z,
  input  logic        ZCOMP,
  output logic        busy,
  output logic        stall,
  output logic        sym_err,
  output logic [15:0] tok_cnt
);

  localparam logic [15:0] PHASE_MAX = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLW = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   zs;
  logic                   last;
  logic [15:0]            phase;
  logic [15:0]            phase_inc;
  logic                   pick;
  logic [1:0]             pick_sym;
  logic                   can_grant;

  // Completion synchronizer: ZCOMP enters at bit 0 and the oldest sample,
  // the top bit, is the only copy the FSM ever looks at.
  always_ff @(posedge clk) begin
    if (init) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ZCOMP};
    end
  end

  assign zs = sync[SYNC_STAGES-1];

  // Arbitration and phase-counter helpers.
  // With both requesting, the one not granted last wins; otherwise the sole
  // requester wins. A grant is blocked while a gnt pulse is still high,
  // because the requester only sees that pulse during this cycle and its
  // req is stale until the following edge (matters after an illegal symbol,
  // which leaves the FSM in IDLE).
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = ~last;
    end
    pick_sym  = pick ? sym1 : sym0;
    can_grant = (state == IDLE) && !zs && (req0 || req1) && !gnt0 && !gnt1;
    phase_inc = (phase != PHASE_MAX) ? phase + 16'd1 : phase;
  end

  // Main handshake FSM. Every output is a register written only here, so Z
  // can only move on a clock edge and is always written as a full one-hot or
  // NULL value. Reaching TIMEOUT in a phase only flags stall; the FSM keeps
  // waiting for the ring.
  always_ff @(posedge clk) begin
    if (init) begin
      state   <= IDLE;
      Z       <= 3'b000;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      stall   <= 1'b0;
      sym_err <= 1'b0;
      tok_cnt <= 16'd0;
      phase   <= 16'd0;
      last    <= 1'b1;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sym_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (can_grant) begin
            gnt0 <= ~pick;
            gnt1 <= pick;
            last <= pick;
            if (pick_sym == 2'd3) begin
              sym_err <= 1'b1;
            end else begin
              Z       <= 3'b001 << pick_sym;
              tok_cnt <= tok_cnt + 16'd1;
              phase   <= 16'd0;
              busy    <= 1'b1;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (zs) begin
            Z     <= 3'b000;
            phase <= 16'd0;
            state <= NULLW;
          end else begin
            phase <= phase_inc;
            if (phase_inc == PHASE_MAX) begin
              stall <= 1'b1;
            end
          end
        end
        NULLW: begin
          if (!zs) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            phase <= phase_inc;
            if (phase_inc == PHASE_MAX) begin
              stall <= 1'b1;
            end
          end
        end
        default: begin
          Z     <= 3'b000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ncl_mr3_arbiter.md
NCL_MR3_ARBITER -- requirements
Module: ncl_mr3_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning: number of flops in the ZCOMP synchronizer; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 255, meaning: handshake-phase cycle limit before stall is flagged; legal range 1..65535.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 init  input  1  reset, synchronous and active-high.
REQ-005 req0  input  1  requester 0 has a symbol pending; held until gnt0.
REQ-006 sym0  input  2  requester 0 symbol, 0..2 legal, 3 illegal.
REQ-007 gnt0  output  1  one-cycle pulse: requester 0 symbol consumed.
REQ-008 req1  input  1  requester 1 has a symbol pending; held until gnt1.
REQ-009 sym1  input  2  requester 1 symbol, 0..2 legal, 3 illegal.
REQ-010 gnt1  output  1  one-cycle pulse: requester 1 symbol consumed.
REQ-011 Z  output  3  1-of-3 multirail channel into the NCL ring stage; 000 = NULL, exactly one rail high = DATA.
REQ-012 ZCOMP  input  1  asynchronous completion from the downstream NCL stage; high = DATA accepted, low = NULL accepted / ready for DATA.
REQ-013 busy  output  1  high while a wavefront is in flight (state DATA or NULLW).
REQ-014 stall  output  1  sticky: a handshake phase exceeded TIMEOUT cycles.
REQ-015 sym_err  output  1  one-cycle pulse: an illegal symbol (3) was consumed.
REQ-016 tok_cnt  output  16  count of DATA wavefronts issued; wraps 0xFFFF -> 0x0000.

Function
REQ-017 ZCOMP SHALL pass through SYNC_STAGES flops before use; zs denotes the synchronizer output.
REQ-018 All outputs SHALL be registered; Z SHALL change only on clk rising edges and never drive more than one rail high.
REQ-019 The FSM SHALL have exactly three states: IDLE, DATA, NULLW.
REQ-020 IDLE: when zs=0 and req0 or req1 is high, the arbiter SHALL select one requester and pulse its gnt on the next edge.
REQ-021 Selection SHALL be round-robin: with both requesting, the requester not granted most recently wins; with one requesting, it wins.
REQ-022 If the selected symbol s is 0..2, the same edge SHALL set Z[s]=1, increment tok_cnt, and enter DATA.
REQ-023 If the selected symbol is 3, the same edge SHALL pulse sym_err, leave Z=000, stay in IDLE, and update the round-robin pointer.
REQ-024 IDLE with zs=1 SHALL issue no grant and hold Z=000.
REQ-025 DATA: Z SHALL be held; when zs=1 the next edge SHALL set Z=000 and enter NULLW.
REQ-026 NULLW: Z SHALL stay 000; when zs=0 the next edge SHALL enter IDLE, and a grant is permitted no earlier than the edge after that.
REQ-027 At most one gnt SHALL be high in any cycle; gnt SHALL NOT be high outside the IDLE exit edge or the illegal-symbol edge.
REQ-028 A phase counter SHALL clear on entry to DATA or NULLW and increment each cycle spent there, saturating at TIMEOUT; reaching TIMEOUT SHALL set stall; the FSM keeps waiting.
REQ-029 A requester dropping req without a grant SHALL be legal; no grant SHALL be issued for it.
REQ-030 Latency from a ZCOMP transition to the responding Z change SHALL be SYNC_STAGES+1 clk cycles.

Reset
REQ-031 init=1 at a rising edge SHALL force: state IDLE, Z=000, gnt0=gnt1=0, busy=0, stall=0, sym_err=0, tok_cnt=0, phase counter 0, synchronizer flops 0, round-robin pointer = last-granted 1 (requester 0 wins first).
REQ-032 init asserted mid-wavefront SHALL abandon the wavefront (Z=000 on that edge) with no grant or count change; the NCL ring is required to be initialized by the same init.

Verification
REQ-033 After reset, req0=1 sym0=2, ZCOMP=0 -> gnt0 pulses one cycle, Z=100, tok_cnt=1; ZCOMP=1 -> Z=000 after 3 cycles; ZCOMP=0 -> IDLE.
REQ-034 req0 and req1 held high continuously, ZCOMP mirroring Z after 2 cycles, 6 wavefronts -> grants alternate 0,1,0,1,0,1, tok_cnt=6.
REQ-035 req1=1 sym1=3 -> gnt1 and sym_err pulse together, Z stays 000, tok_cnt unchanged, next grant with both requesting goes to 0.
REQ-036 TIMEOUT=10, ZCOMP held 0 after DATA issued -> stall=1 after 10 cycles in DATA, Z held; stall cleared only by init.
REQ-037 init pulsed while in DATA with Z=010 -> Z=000, busy=0, tok_cnt=0 on that edge; no gnt.
REQ-038 tok_cnt preset via 65536 wavefronts -> wraps to 0x0000 on the 65536th.
